argmax_stream: RTL

Downstream stage of the fully-connected layer fc_16_8_16_1_8. It consumes that layer's signed T-bit output stream in groups of M values, one group per input vector. For each group it emits the index and value of the largest element, i.e. the class decision. It is stream-compatible on both sides: valid/ready in from the FC layer, and valid/ready out to the next consumer.

---
 rtl/argmax_pkg.sv | 11 +
 rtl/argmax_out_reg.sv | 46 ++++
 rtl/argmax_stream.sv | 87 ++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared types and default sizes for the argmax stage that follows the FC layer.
package argmax_pkg;

  localparam int T_DEF    = 16;
  localparam int M_DEF    = 16;
  localparam int IDXW_DEF = (M_DEF > 1) ? $clog2(M_DEF) : 1;

  typedef logic signed [T_DEF-1:0] data_t;
  typedef logic [IDXW_DEF-1:0]     idx_t;

endpackage

// File: rtl/argmax_out_reg.sv
// Valid/ready holding register for one {index, value} result.
// A load wins over a same-edge clear, so a new result can replace a
// consumed one without a bubble.
module argmax_out_reg
  import argmax_pkg::*;
#(
  parameter int T    = T_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [IDXW-1:0]        load_idx,
  input  logic signed [T-1:0]    load_max,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [IDXW-1:0]        out_idx,
  output logic signed [T-1:0]    out_max
);

  logic                valid_r;
  logic [IDXW-1:0]     idx_r;
  logic signed [T-1:0] max_r;

  // Hold the result until it is accepted; a load takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      idx_r   <= '0;
      max_r   <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      idx_r   <= load_idx;
      max_r   <= load_max;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_idx   = idx_r;
  assign out_max   = max_r;

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over groups of M signed elements: emits the index and value
// of the largest element of each group. Ties keep the lowest index.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int T = T_DEF,
  parameter int M = M_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] output_idx,
  output logic signed [T-1:0] output_max
);

  localparam int IDXW = (M > 1) ? $clog2(M) : 1;

  logic [IDXW-1:0]     cnt_r;
  logic signed [T-1:0] run_max_r;
  logic [IDXW-1:0]     run_idx_r;

  logic                first_s;
  logic                last_s;
  logic                accept_s;
  logic                take_s;
  logic [IDXW-1:0]     win_idx_s;
  logic signed [T-1:0] win_max_s;

  // Element 0 always seeds the running max; later elements replace it only when strictly larger.
  always_comb begin
    first_s   = (cnt_r == '0);
    last_s    = (cnt_r == IDXW'(M - 1));
    accept_s  = input_valid && input_ready;
    take_s    = first_s || (input_data > run_max_r);
    win_idx_s = run_idx_r;
    win_max_s = run_max_r;
    if (take_s) begin
      win_idx_s = cnt_r;
      win_max_s = input_data;
    end else begin
      win_idx_s = run_idx_r;
      win_max_s = run_max_r;
    end
  end

  // Only the last element of a vector may need to wait for the held result to drain.
  assign input_ready = !(last_s && output_valid && !output_ready);

  // Element counter and running maximum; the winner on the last element also feeds the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      run_max_r <= '0;
      run_idx_r <= '0;
    end else if (accept_s) begin
      run_max_r <= win_max_s;
      run_idx_r <= win_idx_s;
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + IDXW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  argmax_out_reg #(
    .T    (T),
    .IDXW (IDXW)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s && last_s),
    .load_idx  (win_idx_s),
    .load_max  (win_max_s),
    .out_ready (output_ready),
    .out_valid (output_valid),
    .out_idx   (output_idx),
    .out_max   (output_max)
  );

endmodule
